rgb2gray_stream: RTL and testbench
==================================

RGB2GRAY_STREAM -- requirements
Module: rgb2gray_stream

Interface
REQ-001 SHALL provide parameter DATA_W, default 8, bits per colour component.
REQ-002 SHALL provide parameter WIDTH, default 768, pixels per line.
REQ-003 SHALL provide parameter HEIGHT, default 512, lines per frame.
REQ-004 SHALL provide parameter OUT_CH, default 3, output channels (1 = single grey; 3 = grey replicated R,G,B).
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port mode  input  1  conversion select (0 = mean, 1 = luma).
REQ-008 SHALL have port s_valid  input  1  input pixel valid.
REQ-009 SHALL have port s_ready  output  1  input pixel accepted when s_valid and s_ready are both high.
REQ-010 SHALL have port s_data  input  3*DATA_W  pixel: R in [DATA_W-1:0], G next, B in the MSBs.
REQ-011 SHALL have port m_valid  output  1  output pixel valid.
REQ-012 SHALL have port m_ready  input  1  downstream ready.
REQ-013 SHALL have port m_data  output  OUT_CH*DATA_W  grey value, replicated OUT_CH times.
REQ-014 SHALL have port m_sof  output  1  high with the first pixel of a frame.
REQ-015 SHALL have port m_eol  output  1  high with the last pixel of each line.
REQ-016 SHALL have port m_eof  output  1  high with the last pixel of a frame.

Function
REQ-017 SHALL implement a two-stage pipeline: stage 1 computes the weighted sum; stage 2 divides/shifts and registers outputs.
REQ-018 SHALL advance both stages only when enable = (!m_valid || m_ready), and SHALL drive s_ready = enable combinationally.
REQ-019 SHALL present an accepted pixel on m_valid exactly 2 enabled cycles after acceptance; with m_ready held high, throughput SHALL be one pixel per clock.
REQ-020 SHALL hold m_data, m_valid and the flags stable while m_valid is high and m_ready is low.
REQ-021 Mode 0: grey SHALL be floor((R+G+B)/3), with the sum held in DATA_W+2 bits.
REQ-022 Mode 1: grey SHALL be (77*R + 150*G + 29*B) >> 8, with the sum held in DATA_W+8 bits; the result SHALL never exceed 2^DATA_W-1.
REQ-023 SHALL sample mode only on acceptance of the first pixel of a frame, and SHALL apply it to that entire frame; mid-frame changes SHALL be ignored.
REQ-024 SHALL keep a column counter (0..WIDTH-1) and a row counter (0..HEIGHT-1), both advancing on each accepted input pixel.
REQ-025 On column wrap (WIDTH-1 to 0), the row counter SHALL increment; on the last pixel (row HEIGHT-1, column WIDTH-1), both counters SHALL return to 0.
REQ-026 SHALL carry sof, eol and eof through the pipeline aligned with their pixel: sof at (0,0); eol at column WIDTH-1; eof at (HEIGHT-1, WIDTH-1), where eol is also set.
REQ-027 Frame n+1 SHALL follow frame n with no idle cycle required.
REQ-028 Internal pipeline valid bits SHALL clear when their data moves on and no new data enters.

Reset
REQ-029 While rst is high: m_valid, m_data, m_sof, m_eol, m_eof, both counters, the latched mode and all pipeline valids SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard in-flight pixels; the first pixel accepted after release SHALL be treated as (0,0) with m_sof set.
REQ-031 s_ready SHALL be 1 during and immediately after reset (since m_valid = 0).

Verification
REQ-032 mode=0, pixel R=30 G=60 B=90, m_ready=1 -> m_data=3C3C3C (OUT_CH=3) with m_valid 2 cycles after acceptance.
REQ-033 mode=1, pixels (255,255,255) then (100,0,0) -> m_data grey 0xFF then 0x1E (7700>>8 = 30).
REQ-034 WIDTH=4, HEIGHT=2, 16 back-to-back pixels -> m_sof on outputs 0 and 8; m_eol on outputs 3,7,11,15; m_eof on outputs 7 and 15.
REQ-035 Stream with m_ready toggled 1-0-0-1 -> s_ready follows enable; output order and values unchanged; no pixel lost or duplicated.
REQ-036 mode switched 0->1 at pixel 2 of a frame -> the whole frame remains mean; the next frame uses luma.
REQ-037 rst pulsed after 5 pixels of a frame -> m_valid=0 immediately; next accepted pixel emerges with m_sof=1.

Source files
------------

// File: rtl/rgb2gray_stream.sv
// rtl/rgb2gray_stream.sv - two-stage RGB to grey stream converter with frame position flags
module rgb2gray_stream #(
    parameter int DATA_W = 8,
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 512,
    parameter int OUT_CH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [3*DATA_W-1:0]      s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [OUT_CH*DATA_W-1:0] m_data,
    output logic                     m_sof,
    output logic                     m_eol,
    output logic                     m_eof
);

    localparam int SUM_W = DATA_W + 8;
    localparam int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

    logic              enable;
    logic              accept;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic              first_px;
    logic              last_col;
    logic              last_row;
    logic              mode_q;
    logic              pix_mode;
    logic [DATA_W-1:0] r, g, b;
    logic [DATA_W+1:0] sum_mean;
    logic [SUM_W-1:0]  sum_luma;

    logic              s1_valid;
    logic              s1_mode;
    logic [SUM_W-1:0]  s1_sum;
    logic              s1_sof, s1_eol, s1_eof;
    logic [DATA_W-1:0] grey_mean;
    logic [DATA_W-1:0] grey_luma;
    logic [DATA_W-1:0] grey;

    // Both stages stall together whenever the output register is full and blocked.
    assign enable = !m_valid || m_ready;
    assign s_ready = enable;
    assign accept = s_valid && enable;

    assign first_px = (col_q == '0) && (row_q == '0);
    assign last_col = (col_q == CW'(WIDTH - 1));
    assign last_row = (row_q == RW'(HEIGHT - 1));

    // The first pixel of a frame uses the live mode input; the rest of the frame uses the latched copy.
    assign pix_mode = first_px ? mode : mode_q;

    assign r = s_data[DATA_W-1:0];
    assign g = s_data[2*DATA_W-1:DATA_W];
    assign b = s_data[3*DATA_W-1:2*DATA_W];

    assign sum_mean = {2'b00, r} + {2'b00, g} + {2'b00, b};
    assign sum_luma = SUM_W'(77) * SUM_W'(r) + SUM_W'(150) * SUM_W'(g) + SUM_W'(29) * SUM_W'(b);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= 1'b0;
        end else if (accept) begin
            if (first_px) begin
                mode_q <= mode;
            end
            if (last_col) begin
                col_q <= '0;
                row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_sum   <= '0;
            s1_sof   <= 1'b0;
            s1_eol   <= 1'b0;
            s1_eof   <= 1'b0;
        end else if (enable) begin
            s1_valid <= s_valid;
            s1_mode  <= pix_mode;
            s1_sum   <= pix_mode ? sum_luma : SUM_W'(sum_mean);
            s1_sof   <= first_px;
            s1_eol   <= last_col;
            s1_eof   <= last_col && last_row;
        end
    end

    // Luma weights sum to 256, so the shifted result always fits in DATA_W bits.
    assign grey_mean = DATA_W'(s1_sum[DATA_W+1:0] / (DATA_W + 2)'(3));
    assign grey_luma = s1_sum[SUM_W-1:8];
    assign grey      = s1_mode ? grey_luma : grey_mean;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_sof   <= 1'b0;
            m_eol   <= 1'b0;
            m_eof   <= 1'b0;
        end else if (enable) begin
            m_valid <= s1_valid;
            m_data  <= {OUT_CH{grey}};
            m_sof   <= s1_sof;
            m_eol   <= s1_eol;
            m_eof   <= s1_eof;
        end
    end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// tb/tb_rgb2gray_stream.sv - scoreboard bench for rgb2gray_stream with a small 4x2 frame
module tb_rgb2gray_stream;

    localparam int W = 4;
    localparam int H = 2;

    typedef struct packed {
        logic [23:0] data;
        logic        sof;
        logic        eol;
        logic        eof;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [23:0] m_data;
    logic        m_sof, m_eol, m_eof;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   pix_idx = 0;
    logic frame_mode = 1'b0;

    rgb2gray_stream #(.DATA_W(8), .WIDTH(W), .HEIGHT(H), .OUT_CH(3)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] pix(input int r, input int g, input int b);
        logic [7:0] r8, g8, b8;
        r8 = r[7:0];
        g8 = g[7:0];
        b8 = b[7:0];
        return {b8, g8, r8};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, req);
        end
    endtask

    // Reference: frame position from a running pixel index, mode fixed at the frame's first pixel.
    task automatic model_accept(input logic [23:0] d, input logic md);
        int r, g, b, grey;
        logic [7:0] g8;
        exp_t e;
        r = int'(d[7:0]);
        g = int'(d[15:8]);
        b = int'(d[23:16]);
        if (pix_idx == 0) frame_mode = md;
        grey = frame_mode ? (77 * r + 150 * g + 29 * b) / 256 : (r + g + b) / 3;
        g8 = grey[7:0];
        e.data = {g8, g8, g8};
        e.sof = (pix_idx == 0);
        e.eol = ((pix_idx % W) == W - 1);
        e.eof = (pix_idx == W * H - 1);
        exp_q.push_back(e);
        pix_idx = (pix_idx + 1) % (W * H);
    endtask

    task automatic cycle(input logic v, input logic [23:0] d, input logic md, input logic mr);
        @(negedge clk);
        s_valid = v;
        s_data  = d;
        mode    = md;
        m_ready = mr;
        #1;
        chk("s_ready_enable", {31'd0, s_ready}, {31'd0, (!m_valid || m_ready)});
        if (v && s_ready) model_accept(d, md);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b0;
        #1;
        exp_q.delete();
        pix_idx = 0;
        chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        chk("rst_flags", {29'd0, m_sof, m_eol, m_eof}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    exp_t        mon_e;
    logic        prev_stall = 1'b0;
    logic [26:0] prev_out;

    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_valid || {m_data, m_sof, m_eol, m_eof} !== prev_out) begin
                    errors++;
                    $display("FAIL hold_stable got=%h valid=%b expected=%h", {m_data, m_sof, m_eol, m_eof}, m_valid, prev_out);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output got=%h expected=none", {m_data, m_sof, m_eol, m_eof});
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({m_data, m_sof, m_eol, m_eof} !== mon_e) begin
                        errors++;
                        $display("FAIL pixel_out got=%h sof/eol/eof=%b%b%b expected=%h sof/eol/eof=%b%b%b",
                                 m_data, m_sof, m_eol, m_eof, mon_e.data, mon_e.sof, mon_e.eol, mon_e.eof);
                    end
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_out   = {m_data, m_sof, m_eol, m_eof};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_valid = 1'b0;
        s_data = '0;
        mode = 1'b0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_m_valid", {31'd0, m_valid}, 32'd0);
        chk("reset_m_data", {8'd0, m_data}, 32'd0);
        chk("reset_flags", {29'd0, m_sof, m_eol, m_eof}, 32'd0);
        chk("reset_s_ready", {31'd0, s_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;

        // Mean of (30,60,90) with two-cycle latency
        cycle(1'b1, pix(30, 60, 90), 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("latency_1_not_valid", {31'd0, m_valid}, 32'd0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("latency_2_valid", {31'd0, m_valid}, 32'd1);
        chk("mean_3c", {8'd0, m_data}, 32'h003C3C3C);
        chk("first_sof", {31'd0, m_sof}, 32'd1);
        for (int i = 0; i < 7; i++) cycle(1'b1, 24'($urandom), 1'b0, 1'b1);

        // Luma frame: white then pure red 100
        cycle(1'b1, pix(255, 255, 255), 1'b1, 1'b1);
        cycle(1'b1, pix(100, 0, 0), 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("luma_white", {8'd0, m_data}, 32'h00FFFFFF);
        cycle(1'b0, '0, 1'b1, 1'b1);
        chk("luma_red100", {8'd0, m_data}, 32'h001E1E1E);
        for (int i = 0; i < 6; i++) cycle(1'b1, 24'($urandom), 1'b1, 1'b1);

        // Two frames back to back
        for (int i = 0; i < 16; i++) cycle(1'b1, 24'($urandom), 1'($urandom), 1'b1);

        // Backpressure pattern 1-0-0-1
        for (int i = 0; i < 16; i++) cycle(1'b1, 24'($urandom), 1'($urandom), (i % 4 == 0) || (i % 4 == 3));

        for (int i = 0; i < 40 && pix_idx != 0; i++) cycle(1'b1, 24'($urandom), 1'b0, 1'b1);
        chk("frame_sync", pix_idx, 0);

        // Mode flips to luma at pixel 2; only the next frame is luma
        for (int i = 0; i < 8; i++) cycle(1'b1, 24'($urandom), i >= 2, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1, 24'($urandom), 1'b1, 1'b1);

        // Reset after 5 pixels of a frame
        for (int i = 0; i < 5; i++) cycle(1'b1, 24'($urandom), 1'b0, 1'b1);
        pulse_reset();
        for (int i = 0; i < 8; i++) cycle(1'b1, 24'($urandom), 1'b1, 1'b1);

        for (int i = 0; i < 300; i++)
            cycle($urandom_range(3) != 0, 24'($urandom), 1'($urandom), $urandom_range(9) < 7);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
